dpll_trim_controller: RTL
=========================

DPLL_TRIM_CONTROLLER -- requirements
Module: dpll_trim_controller

Interface
REQ-001 The block SHALL use one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Parameter TRIM_W, default 26: width of the thermometer trim word.
REQ-003 Parameter DIV_W, default 5: width of the division-ratio input.
REQ-004 Parameter TRIM_INIT, default 13: trim value (tval) loaded at reset, range 0..TRIM_W.
REQ-005 Parameter TOL, default 0: half-width of the lock window, in clock cycles.
REQ-006 Parameter LOCK_CNT, default 4: number of consecutive in-window measurements required for lock.
REQ-007 Derived constant CNT_W = DIV_W+2: width of the period counter.
REQ-008 Port clock, input, 1: DCO clock; all state updates on its rising edge.
REQ-009 Port reset, input, 1: synchronous, active-high.
REQ-010 Port osc, input, 1: reference oscillator, asynchronous to clock.
REQ-011 Port div, input, DIV_W: target DCO cycles per osc period.
REQ-012 Port dco, input, 1: 1 selects external trim (open-loop) mode.
REQ-013 Port ext_trim, input, TRIM_W: trim word applied while dco=1.
REQ-014 Port trim, output, TRIM_W: registered trim word to the ring oscillator.
REQ-015 Port lock, output, 1: registered frequency-lock flag.

Function
REQ-016 osc SHALL pass through a 2-flop synchronizer followed by a rising-edge detector, producing a one-cycle strobe 3 clock cycles after the osc edge.
REQ-017 The period counter SHALL clear to 1 in each strobe cycle and increment otherwise, saturating at 2^CNT_W-1.
REQ-018 The measured period P SHALL be the counter value in the strobe cycle, i.e. the number of clock cycles between consecutive strobes.
REQ-019 The first strobe after reset, and the first strobe after dco falls, SHALL be discarded: no trim change and no lock-count change.
REQ-020 For each valid strobe, with lo = max(div-TOL, 0) and hi = div+TOL computed at CNT_W width:
  - P > hi: tval increments by 1 (more delay, lower frequency).
  - P < lo: tval decrements by 1.
  - otherwise: tval holds.
REQ-021 tval SHALL saturate at 0 and at TRIM_W.
REQ-022 div=0 SHALL suppress all tval updates and force lock to 0.
REQ-023 div SHALL be sampled in the strobe cycle only.
REQ-024 trim SHALL equal the thermometer code of tval (trim[i]=1 iff i<tval), registered, one cycle after the strobe.
REQ-025 While dco=1:
  - trim = ext_trim, registered with one-cycle latency.
  - tval frozen.
  - lock = 0.
  - period counter keeps running.
REQ-026 A strobe coincident with dco=1 SHALL perform no update.
REQ-027 When dco falls, trim SHALL return to the thermometer code of the frozen tval on the next cycle.
REQ-028 If osc stops, no strobes occur, and tval and lock SHALL hold.

Reset
REQ-029 In any cycle with reset=1, the next state SHALL be:
  - tval=TRIM_INIT, trim=thermometer(TRIM_INIT).
  - lock=0, lock counter=0.
  - period counter=0, synchronizer and edge flops=0.
  - first-strobe discard flag armed.
REQ-030 Reset asserted mid-measurement or mid-dco SHALL abandon the measurement, with no partial update.

Configuration
REQ-031 With macro DPLL_LOCK_DETECT_EN defined:
  - A lock counter SHALL increment on each valid in-window strobe, saturating at LOCK_CNT.
  - The lock counter SHALL clear on any out-of-window strobe, on dco=1, or on div=0.
  - lock=1 iff the lock counter equals LOCK_CNT.
REQ-032 Without DPLL_LOCK_DETECT_EN, lock SHALL be tied to 0 and no lock counter logic SHALL exist.

Structure
REQ-033 Parameter defaults, the CNT_W derivation and the thermometer-encode function SHALL reside in shared package dpll_ctrl_pkg.
REQ-034 The synchronizer and edge detector SHALL be sub-module dpll_osc_sync (ports clock, reset, osc, strobe), instantiated once.

Verification
Scenarios use default parameters, TOL=0, DPLL_LOCK_DETECT_EN defined.
REQ-035 Reset: reset=1 for 2 cycles -> trim=26'h0001FFF, lock=0.
REQ-036 Too fast: div=8, osc period 10 clocks -> after the discarded first strobe, tval steps 13->14->15->16 over 3 strobes; trim=26'h000FFFF.
REQ-037 Lock: div=8, osc period 8 clocks -> tval stays 13; lock rises one cycle after the 4th valid strobe (5th strobe overall); a single 9-clock period then clears lock and sets tval=14.
REQ-038 Saturation: div=31, osc period 4 clocks -> tval decrements to 0 and stays 0; trim=0.
REQ-039 Open-loop: dco=1, ext_trim=26'h3FFFFFF -> next cycle trim=26'h3FFFFFF and lock=0; dco=0 -> next cycle trim=thermometer(frozen tval); the first strobe after that causes no update.
REQ-040 Reset mid-run: tval=20, one-cycle reset coincident with a strobe -> next cycle tval=13 and lock=0.

Source files
------------

// File: rtl/dpll_ctrl_pkg.sv
// Shared constants and helpers for the DPLL trim controller.
// Holds the parameter defaults, the period-counter width derivation and the
// thermometer encoder used to drive the ring-oscillator trim word.
package dpll_ctrl_pkg;

    localparam int TRIM_W_DEF    = 26;
    localparam int DIV_W_DEF     = 5;
    localparam int TRIM_INIT_DEF = 13;
    localparam int TOL_DEF       = 0;
    localparam int LOCK_CNT_DEF  = 4;

    // Widest trim word the encoder can produce; callers truncate to their width.
    localparam int THERM_MAX = 64;

    // Period counter is two bits wider than the division ratio so that a
    // period of up to ~4x the target can still be told apart from saturation.
    function automatic int cnt_width(input int div_w);
        return div_w + 2;
    endfunction

    // Thermometer code: bit i is set iff i < level.
    function automatic logic [THERM_MAX-1:0] therm_encode(input int level);
        logic [THERM_MAX-1:0] code;
        code = '0;
        for (int i = 0; i < THERM_MAX; i++) begin
            code[i] = (i < level);
        end
        return code;
    endfunction

endpackage

// File: rtl/dpll_osc_sync.sv
// Brings the asynchronous reference oscillator into the DCO clock domain.
// Two synchronizer flops, an edge-history flop and a registered rising-edge
// strobe: the strobe is high for one cycle, three clocks after an osc rise.
module dpll_osc_sync (
    input  logic clock,
    input  logic reset,
    input  logic osc,
    output logic strobe
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q, prev_d;
    logic strobe_q, strobe_d;

    // Shift osc through the synchronizer and flag a low-to-high transition.
    always_comb begin
        sync1_d  = osc;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        strobe_d = sync2_q & ~prev_q;
    end

    // State registers; reset clears the whole chain so no stale edge survives.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/dpll_trim_controller.sv
// DPLL trim controller: measures the reference-oscillator period in DCO
// clock cycles and nudges a thermometer-coded trim word one step per
// reference period until the period matches div (within +/-TOL).
// Open-loop mode (dco=1) passes ext_trim through and freezes the loop.
// Optional feature macro: DPLL_LOCK_DETECT_EN adds the lock counter/flag;
// without it lock is tied low.
module dpll_trim_controller
    import dpll_ctrl_pkg::*;
#(
    parameter int TRIM_W    = TRIM_W_DEF,
    parameter int DIV_W     = DIV_W_DEF,
    parameter int TRIM_INIT = TRIM_INIT_DEF,
    parameter int TOL       = TOL_DEF,
    parameter int LOCK_CNT  = LOCK_CNT_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              osc,
    input  logic [DIV_W-1:0]  div,
    input  logic              dco,
    input  logic [TRIM_W-1:0] ext_trim,
    output logic [TRIM_W-1:0] trim,
    output logic              lock
);

    localparam int CNT_W  = cnt_width(DIV_W);
    localparam int TVAL_W = $clog2(TRIM_W + 1);

    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;
    localparam logic [CNT_W-1:0]  TOL_C      = CNT_W'(TOL);
    localparam logic [TVAL_W-1:0] TVAL_MAX   = TVAL_W'(TRIM_W);
    localparam logic [TVAL_W-1:0] TVAL_INIT  = TVAL_W'(TRIM_INIT);
    localparam logic [TRIM_W-1:0] TRIM_RESET = TRIM_W'(therm_encode(TRIM_INIT));

    // An out-of-range configuration stops elaboration instead of misbehaving.
    if (TRIM_INIT < 0 || TRIM_INIT > TRIM_W || TRIM_W > THERM_MAX || LOCK_CNT < 1) begin : g_param_check
        $error("dpll_trim_controller: illegal parameter combination");
    end

    logic              strobe;
    logic              valid;
    logic              too_slow;
    logic              too_fast;
    logic [CNT_W-1:0]  div_ext;
    logic [CNT_W-1:0]  win_lo;
    logic [CNT_W-1:0]  win_hi;

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              first_q, first_d;
    logic [TVAL_W-1:0] tval_q, tval_d;
    logic [TRIM_W-1:0] trim_q, trim_d;

    dpll_osc_sync u_osc_sync (
        .clock  (clock),
        .reset  (reset),
        .osc    (osc),
        .strobe (strobe)
    );

    // Classify the measured period (cnt_q in the strobe cycle) against the window.
    always_comb begin
        div_ext  = CNT_W'(div);
        win_hi   = div_ext + TOL_C;
        win_lo   = (div_ext > TOL_C) ? (div_ext - TOL_C) : '0;
        valid    = strobe & ~dco & ~first_q;
        too_slow = (cnt_q > win_hi);
        too_fast = (cnt_q < win_lo);
    end

    // Period counter, discard flag, trim value and the registered trim word.
    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        tval_d  = tval_q;

        if (strobe) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // The first strobe after reset or after open-loop spans an unknown
        // interval, so it only re-arms the measurement.
        if (dco) begin
            first_d = 1'b1;
        end else if (strobe) begin
            first_d = 1'b0;
        end

        // A slow period means the DCO runs fast: add delay, and vice versa.
        if (valid && (div != '0)) begin
            if (too_slow && (tval_q < TVAL_MAX)) begin
                tval_d = tval_q + TVAL_W'(1);
            end else if (too_fast && (tval_q != '0)) begin
                tval_d = tval_q - TVAL_W'(1);
            end
        end

        trim_d = dco ? ext_trim : TRIM_W'(therm_encode(int'(tval_d)));
    end

    // Loop state registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q   <= '0;
            first_q <= 1'b1;
            tval_q  <= TVAL_INIT;
            trim_q  <= TRIM_RESET;
        end else begin
            cnt_q   <= cnt_d;
            first_q <= first_d;
            tval_q  <= tval_d;
            trim_q  <= trim_d;
        end
    end

    assign trim = trim_q;

`ifdef DPLL_LOCK_DETECT_EN
    localparam int LCNT_W = $clog2(LOCK_CNT + 1);
    localparam logic [LCNT_W-1:0] LCNT_MAX = LCNT_W'(LOCK_CNT);

    logic              in_window;
    logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              lock_q, lock_d;

    // Count consecutive in-window periods; any disturbance restarts the count.
    always_comb begin
        in_window  = ~too_slow & ~too_fast;
        lock_cnt_d = lock_cnt_q;
        if (dco || (div == '0)) begin
            lock_cnt_d = '0;
        end else if (valid) begin
            if (!in_window) begin
                lock_cnt_d = '0;
            end else if (lock_cnt_q != LCNT_MAX) begin
                lock_cnt_d = lock_cnt_q + LCNT_W'(1);
            end
        end
        lock_d = (lock_cnt_d == LCNT_MAX);
    end

    // Lock counter and registered lock flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_cnt_q <= '0;
            lock_q     <= 1'b0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
            lock_q     <= lock_d;
        end
    end

    assign lock = lock_q;
`else
    assign lock = 1'b0;
`endif

endmodule
